// File: rtl/axis_rr_arbiter_pkg.sv
// Shared definitions for the AXI-Stream round-robin packet arbiter.
package axis_rr_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int N_PORTS_MIN = 2;
  localparam int N_PORTS_MAX = 8;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream register slice: one output register plus one skid register.
module axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         arstn_i,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         in_fire;

  // Ready depends only on the skid register, so it never loops back from out_ready.
  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) out_data <= in_data;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter merging N AXI-Stream sources into one,
// with a two-entry register slice on the output.
module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk_i,
  input  logic                          arstn_i,
  input  logic [N_PORTS-1:0]            s_tvalid_i,
  output logic [N_PORTS-1:0]            s_tready_o,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_tdata_i,
  input  logic [N_PORTS-1:0]            s_tlast_i,
  input  logic [N_PORTS-1:0]            en_i,
  output logic                          m_tvalid_o,
  input  logic                          m_tready_i,
  output logic [DATA_WIDTH-1:0]         m_tdata_o,
  output logic                          m_tlast_o,
  output logic [ID_WIDTH-1:0]           m_tid_o,
  output logic                          busy_o
);

  localparam int PW = DATA_WIDTH + 1 + ID_WIDTH;

  if (N_PORTS < N_PORTS_MIN || N_PORTS > N_PORTS_MAX) begin : g_bad_n_ports
    $error("axis_rr_arbiter: N_PORTS out of range");
  end

  state_t                state;
  logic [ID_WIDTH-1:0]   grant;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   pick;
  logic                  any_elig;
  logic [N_PORTS-1:0]    elig;
  logic                  buf_in_valid;
  logic                  buf_in_ready;
  logic                  in_fire;
  logic                  in_last;
  logic [DATA_WIDTH-1:0] in_data;
  logic [PW-1:0]         buf_out;
  int                    j;

  assign elig = s_tvalid_i & en_i;

  // First eligible port at or after rr_ptr, wrapping at N_PORTS.
  always_comb begin
    pick     = '0;
    any_elig = 1'b0;
    j        = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= N_PORTS) j = j - N_PORTS;
      if (!any_elig && elig[j]) begin
        any_elig = 1'b1;
        pick     = ID_WIDTH'(j);
      end
    end
  end

  assign buf_in_valid = (state == LOCKED) && s_tvalid_i[grant];
  assign in_fire      = buf_in_valid && buf_in_ready;
  assign in_last      = s_tlast_i[grant];
  assign in_data      = s_tdata_i[grant*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    s_tready_o = '0;
    if (state == LOCKED) s_tready_o[grant] = buf_in_ready;
  end

  // en_i only matters when choosing a winner; a granted packet always runs to tlast.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_elig) begin
            grant  <= pick;
            state  <= LOCKED;
            busy_o <= 1'b1;
          end
        end
        LOCKED: begin
          if (in_fire && in_last) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            rr_ptr <= (grant == ID_WIDTH'(N_PORTS - 1)) ? '0 : grant + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  axis_skid_buf #(.W(PW)) u_obuf (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .in_valid  (buf_in_valid),
    .in_ready  (buf_in_ready),
    .in_data   ({in_data, in_last, grant}),
    .out_valid (m_tvalid_o),
    .out_ready (m_tready_i),
    .out_data  (buf_out)
  );

  assign {m_tdata_o, m_tlast_o, m_tid_o} = buf_out;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-cycle vector table plus packet-level sequences.
module tb_axis_rr_arbiter;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic              clk_i = 1'b0;
  logic              arstn_i;
  logic [NP-1:0]     s_tvalid_i;
  logic [NP-1:0]     s_tready_o;
  logic [NP*DW-1:0]  s_tdata_i;
  logic [NP-1:0]     s_tlast_i;
  logic [NP-1:0]     en_i;
  logic              m_tvalid_o;
  logic              m_tready_i;
  logic [DW-1:0]     m_tdata_o;
  logic              m_tlast_o;
  logic [IW-1:0]     m_tid_o;
  logic              busy_o;

  axis_rr_arbiter #(.N_PORTS(NP), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .s_tdata_i(s_tdata_i),
    .s_tlast_i(s_tlast_i), .en_i(en_i),
    .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tdata_o(m_tdata_o),
    .m_tlast_o(m_tlast_o), .m_tid_o(m_tid_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         rst;
    logic [3:0] vld;
    logic [3:0] en;
    logic       busy;
    logic [3:0] sr;
    logic       mv;
    logic [1:0] tid;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic [IW-1:0] id;
    int            cyc;
  } beat_t;

  vec_t          vt [14];
  logic [DW:0]   srcq [NP][$];
  beat_t         rxq [$];
  int            cyc_n;
  int            in_cnt [NP];
  logic          tog;
  logic          prev_stall;
  logic [DW+IW:0] prev_out;
  logic          sr2_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rx(input string nm, input int i, input int d, input bit l, input int id);
    if (i < rxq.size()) begin
      chk({nm, "_data"}, 32'(rxq[i].d), 32'(d));
      chk({nm, "_last"}, 32'(rxq[i].l), 32'(l));
      chk({nm, "_tid"}, 32'(rxq[i].id), 32'(id));
    end else begin
      checks++;
      failures++;
      $display("FAIL %s: beat %0d missing, got %0d beats", nm, i, rxq.size());
    end
  endtask

  task automatic push_pkt(input int p, input int base, input int n);
    for (int i = 0; i < n; i++) srcq[p].push_back({DW'(base + i), (i == n - 1)});
  endtask

  task automatic drive_srcs();
    for (int k = 0; k < NP; k++) begin
      if (srcq[k].size() > 0) begin
        s_tvalid_i[k] = 1'b1;
        s_tdata_i[k*DW +: DW] = srcq[k][0][DW:1];
        s_tlast_i[k] = srcq[k][0][0];
      end else begin
        s_tvalid_i[k] = 1'b0;
        s_tdata_i[k*DW +: DW] = '0;
        s_tlast_i[k] = 1'b0;
      end
    end
  endtask

  // One clock: sample at negedge, advance sources just after the posedge.
  task automatic step();
    logic [NP-1:0] hs;
    if (prev_stall) begin
      chk("stall_valid", 32'(m_tvalid_o), 32'd1);
      chk("stall_payload", 32'({m_tdata_o, m_tlast_o, m_tid_o}), 32'(prev_out));
    end
    prev_stall = m_tvalid_o & ~m_tready_i;
    prev_out = {m_tdata_o, m_tlast_o, m_tid_o};
    hs = s_tvalid_i & s_tready_o;
    if (s_tready_o[2]) sr2_seen = 1'b1;
    if (m_tvalid_o && m_tready_i) rxq.push_back('{m_tdata_o, m_tlast_o, m_tid_o, cyc_n});
    @(posedge clk_i);
    #1;
    for (int k = 0; k < NP; k++) begin
      if (hs[k]) begin
        srcq[k].delete(0);
        in_cnt[k]++;
      end
    end
    drive_srcs();
    if (tog) m_tready_i = ~m_tready_i;
    cyc_n++;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    arstn_i = 1'b0;
    s_tvalid_i = '0;
    s_tdata_i = '0;
    s_tlast_i = '0;
    en_i = '1;
    m_tready_i = 1'b1;
    tog = 1'b0;
    prev_stall = 1'b0;
    sr2_seen = 1'b0;
    cyc_n = 0;
    for (int k = 0; k < NP; k++) begin
      srcq[k].delete();
      in_cnt[k] = 0;
    end
    rxq.delete();
    repeat (2) @(negedge clk_i);
    arstn_i = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    // 1-beat packets from all ports, then masked arbitration.
    vt[0]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    vt[1]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    vt[2]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0};
    vt[3]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
    vt[4]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0, 2'd0};
    vt[5]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};
    vt[6]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0, 2'd0};
    vt[7]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
    vt[8]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    vt[9]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    vt[10] = '{1'b1, 4'b1010, 4'b1101, 1'b1, 4'b1000, 1'b0, 2'd0};
    vt[11] = '{1'b0, 4'b1010, 4'b1101, 1'b0, 4'b0000, 1'b1, 2'd3};
    vt[12] = '{1'b0, 4'b1010, 4'b1101, 1'b1, 4'b1000, 1'b0, 2'd0};
    vt[13] = '{1'b0, 4'b1010, 4'b1101, 1'b0, 4'b0000, 1'b1, 2'd3};

    arstn_i = 1'b0;
    s_tvalid_i = '0;
    s_tdata_i = '0;
    s_tlast_i = '0;
    en_i = '0;
    m_tready_i = 1'b0;
    tog = 1'b0;
    prev_stall = 1'b0;
    #2;
    chk("rst_m_tvalid", 32'(m_tvalid_o), 32'd0);
    chk("rst_m_tdata", 32'(m_tdata_o), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast_o), 32'd0);
    chk("rst_m_tid", 32'(m_tid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_s_tready", 32'(s_tready_o), 32'd0);

    for (int i = 0; i < 14; i++) begin
      v = vt[i];
      if (v.rst) do_reset();
      s_tvalid_i = v.vld;
      en_i = v.en;
      s_tlast_i = '1;
      s_tdata_i = 32'hA3A2A1A0;
      m_tready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      chk($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(v.busy));
      chk($sformatf("vec%0d_s_tready", i), 32'(s_tready_o), 32'(v.sr));
      chk($sformatf("vec%0d_m_tvalid", i), 32'(m_tvalid_o), 32'(v.mv));
      if (v.mv) begin
        chk($sformatf("vec%0d_tid", i), 32'(m_tid_o), 32'(v.tid));
        chk($sformatf("vec%0d_tdata", i), 32'(m_tdata_o), 32'(8'hA0 + 8'(v.tid)));
        chk($sformatf("vec%0d_tlast", i), 32'(m_tlast_o), 32'd1);
      end
    end

    // Two 3-beat packets: port 0 then port 2, one bubble between packets.
    do_reset();
    push_pkt(0, 8'h10, 3);
    push_pkt(2, 8'h20, 3);
    drive_srcs();
    for (int i = 0; i < 40 && rxq.size() < 6; i++) step();
    chk("two_pkt_count", 32'(rxq.size()), 32'd6);
    for (int i = 0; i < 3; i++) chk_rx("two_pkt_p0", i, 8'h10 + i, i == 2, 0);
    for (int i = 0; i < 3; i++) chk_rx("two_pkt_p2", i + 3, 8'h20 + i, i == 2, 2);
    if (rxq.size() >= 4) begin
      chk("two_pkt_thru", 32'(rxq[2].cyc - rxq[0].cyc), 32'd2);
      chk("two_pkt_gap", 32'(rxq[3].cyc - rxq[2].cyc), 32'd2);
    end

    // 8-beat packet with downstream ready toggling every cycle.
    do_reset();
    push_pkt(0, 8'h30, 8);
    drive_srcs();
    tog = 1'b1;
    for (int i = 0; i < 80 && rxq.size() < 8; i++) step();
    chk("stall_pkt_count", 32'(rxq.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk_rx("stall_pkt", i, 8'h30 + i, i == 7, 0);
    tog = 1'b0;

    // Reset in the middle of a port-1 packet, with rr_ptr moved off 0 beforehand.
    do_reset();
    push_pkt(0, 8'h40, 1);
    push_pkt(1, 8'h50, 5);
    drive_srcs();
    for (int i = 0; i < 40 && (in_cnt[0] + in_cnt[1]) < 3; i++) step();
    chk("midrst_in_beats", 32'(in_cnt[0] + in_cnt[1]), 32'd3);
    chk("midrst_pre_busy", 32'(busy_o), 32'd1);
    arstn_i = 1'b0;
    #1;
    chk("midrst_m_tvalid", 32'(m_tvalid_o), 32'd0);
    chk("midrst_m_tdata", 32'(m_tdata_o), 32'd0);
    chk("midrst_m_tlast", 32'(m_tlast_o), 32'd0);
    chk("midrst_m_tid", 32'(m_tid_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_s_tready", 32'(s_tready_o), 32'd0);
    for (int k = 0; k < NP; k++) srcq[k].delete();
    rxq.delete();
    prev_stall = 1'b0;
    drive_srcs();
    @(negedge clk_i);
    arstn_i = 1'b1;
    push_pkt(0, 8'h60, 1);
    push_pkt(1, 8'h61, 1);
    drive_srcs();
    for (int i = 0; i < 40 && rxq.size() < 2; i++) step();
    chk("postrst_count", 32'(rxq.size()), 32'd2);
    chk_rx("postrst_first", 0, 8'h60, 1'b1, 0);
    chk_rx("postrst_second", 1, 8'h61, 1'b1, 1);

    // Port 2 disabled mid-packet: packet finishes, next port-2 packet never granted.
    do_reset();
    push_pkt(0, 8'h70, 1);
    push_pkt(2, 8'h80, 4);
    push_pkt(2, 8'h84, 1);
    drive_srcs();
    for (int i = 0; i < 60 && rxq.size() < 5; i++) begin
      step();
      if (in_cnt[2] >= 1) en_i = 4'b1011;
    end
    chk("endis_count", 32'(rxq.size()), 32'd5);
    chk_rx("endis_p0", 0, 8'h70, 1'b1, 0);
    for (int i = 0; i < 4; i++) chk_rx("endis_p2", i + 1, 8'h80 + i, i == 3, 2);
    sr2_seen = 1'b0;
    repeat (12) step();
    chk("endis_no_regrant", 32'(rxq.size()), 32'd5);
    chk("endis_ready2_low", 32'(sr2_seen), 32'd0);
    chk("endis_idle", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
